edabk_uart_rx_engine: RTL and testbench
=======================================

// Module: edabk_uart_rx_engine
// PURPOSE
//  Parametrised UART receive engine: oversamples the serial line, recovers frames of configurable data
//  width, optional parity and 1/2 stop bits, and presents bytes on a valid/ready interface.
//  Adds majority-vote sampling, false-start rejection, parity/framing/overrun/break detection and a
//  one-entry output holding register. Sits between the pad-side rx line and the receive FIFO.
// PARAMETERS
//  CLK_DIV     16  bclk cycles per bit (oversampling ratio); legal 8..64, must be even
//  DATA_WIDTH  8   maximum data bits per frame; legal 5..9
//  SYNC_STAGES 2   rx input synchroniser depth; legal 2..3
// PORTS
//  bclk           in   1                    oversampling clock, CLK_DIV x baud rate
//  reset          in   1                    synchronous reset, active high
//  rx             in   1                    asynchronous serial line, idle high
//  cfg_data_bits  in   $clog2(DATA_WIDTH+1) data bits per frame, 5..DATA_WIDTH
//  cfg_parity_en  in   1                    1 = parity bit follows data
//  cfg_parity_odd in   1                    1 = odd parity, 0 = even
//  cfg_stop2      in   1                    1 = two stop bits checked
//  rx_data        out  DATA_WIDTH           received data, LSB first on wire, unused MSBs zero
//  rx_valid       out  1                    rx_data/status held valid
//  rx_ready       in   1                    consumer accepts when rx_valid & rx_ready
//  err_parity     out  1                    parity mismatch on the held frame
//  err_frame      out  1                    stop-bit sample was 0 on the held frame
//  err_overrun    out  1                    sticky: frame lost because holding reg was full
//  break_det      out  1                    held frame was all-zero incl. stop bit
//  busy           out  1                    engine is not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, synchroniser flops loaded with 1, counters 0.
//  - Sample s = majority of synced rx at bit-counter values CLK_DIV/2-1, CLK_DIV/2, CLK_DIV/2+1;
//    decided on cycle CLK_DIV/2+1. Bit counter counts 0..CLK_DIV-1 and wraps.
//  - cfg_* sampled into shadow regs on IDLE->START; changes mid-frame have no effect.
//  - FSM: IDLE -(synced rx=0)-> START, counter cleared.
//    START: at sample point s=1 -> IDLE (false start, nothing reported); s=0 -> DATA at end of bit.
//    DATA: cfg_data_bits samples shifted LSB first; -> PARITY if parity_en, else STOP.
//    PARITY: sample compared with XOR(data)^odd; mismatch sets frame parity flag.
//    STOP: first stop bit sampled; if cfg_stop2 and s=1, second stop bit also sampled.
//      Frame completes on the cycle of the final stop sample; no wait for end of bit.
//      Any stop sample 0 -> frame error; if data all zero too -> break.
//      Complete with s=1 -> IDLE (resync on next falling edge mid-bit allowed);
//      error -> WAIT_IDLE until synced rx=1, then IDLE.
//  - Completion, cycle N: if !rx_valid or (rx_valid & rx_ready) in cycle N, load rx_data/err_parity/
//    err_frame/break_det; rx_valid=1 from cycle N+1. Otherwise frame dropped, err_overrun set.
//  - Handshake: rx_valid & rx_ready in a cycle with no completion -> rx_valid=0 next cycle.
//    Data/status stable while rx_valid & !rx_ready.
//  - err_overrun is sticky; cleared only by reset or by an accepting handshake.
//  - busy = (state != IDLE).
//  - Latency, start-bit edge to rx_valid, 8N1: SYNC_STAGES + 9*CLK_DIV + CLK_DIV/2 + 2 bclk.
//  - reset mid-frame: discard partial frame, return to IDLE next cycle, all outputs 0.
// TESTING
//  - 8N1, CLK_DIV=16, send 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid 1 cycle, no error flags.
//  - 8E1 send 0x3C with parity bit 1 -> rx_data=0x3C, err_parity=1; with parity bit 0 -> no error.
//  - 7O2 send 0x55, second stop bit 0 -> err_frame=1; FSM stays WAIT_IDLE until rx high.
//  - rx low 3 bclk then high (glitch) -> no rx_valid, busy drops back to 0 by mid-start bit.
//  - rx held low 2 frames -> break_det=1, err_frame=1, rx_data=0; single frame reported.
//  - rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, err_overrun=1; handshake clears it.

Source files
------------

// File: rtl/edabk_uart_rx_engine_if.sv
// Receive holding-register port: byte, frame status and the valid/ready handshake.
// The engine drives through master; the receive FIFO side uses slave.
interface edabk_uart_rx_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  err_parity;
  logic                  err_frame;
  logic                  err_overrun;
  logic                  break_det;

  modport master (
    output rx_data, rx_valid, err_parity, err_frame, err_overrun, break_det,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, err_parity, err_frame, err_overrun, break_det,
    output rx_ready
  );
endinterface

// File: rtl/edabk_uart_rx_engine.sv
// Oversampling UART receiver: majority-vote bit recovery, configurable frame format,
// parity/framing/break/overrun detection and a one-entry output holding register.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | line idle, waiting for a synced falling edge
//   ST_START     | validating start bit; a high mid-bit sample is a false start
//   ST_DATA      | shifting data bits, LSB first
//   ST_PARITY    | sampling and checking the parity bit
//   ST_STOP      | sampling one or two stop bits; frame completes at last sample
//   ST_WAIT_IDLE | framing error seen, waiting for the line to return high
module edabk_uart_rx_engine #(
  parameter int CLK_DIV     = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            bclk,
  input  logic                            reset,
  input  logic                            rx,
  input  logic [$clog2(DATA_WIDTH+1)-1:0] cfg_data_bits,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_parity_odd,
  input  logic                            cfg_stop2,
  edabk_uart_rx_engine_if.master          rx_if,
  output logic                            busy
);

  localparam int CW  = $clog2(CLK_DIV);
  localparam int NBW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0]  C_S0   = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0]  C_S1   = CW'(CLK_DIV/2);
  localparam logic [CW-1:0]  C_DEC  = CW'(CLK_DIV/2 + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(CLK_DIV - 1);
  localparam logic [NBW-1:0] NB_MIN = NBW'(5);
  localparam logic [NBW-1:0] NB_MAX = NBW'(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync;
  logic [CW-1:0]           cnt;
  logic                    v_a;
  logic                    v_b;
  logic [DATA_WIDTH-1:0]   data_sh;
  logic [NBW-1:0]          bit_idx;
  logic [NBW-1:0]          nb_q;
  logic                    par_en_q;
  logic                    odd_q;
  logic                    stop2_q;
  logic                    stop_idx;
  logic                    perr_q;

  logic [DATA_WIDTH-1:0]   data_o;
  logic                    valid_o;
  logic                    perr_o;
  logic                    ferr_o;
  logic                    brk_o;
  logic                    ovr_o;

  logic                    rx_s;
  logic                    maj;
  logic                    counting;
  logic                    done;
  logic                    hold_free;
  logic [NBW-1:0]          nb_clamped;
  logic [DATA_WIDTH-1:0]   aligned;

  assign rx_s     = sync[SYNC_STAGES-1];
  assign maj      = (v_a & v_b) | (v_a & rx_s) | (v_b & rx_s);
  assign counting = (state == ST_START) || (state == ST_DATA) ||
                    (state == ST_PARITY) || (state == ST_STOP);

  // The final stop sample is either a low first stop or the last one configured.
  assign done      = (state == ST_STOP) && (cnt == C_DEC) &&
                     (!maj || !(stop2_q && !stop_idx));
  assign hold_free = !valid_o || rx_if.rx_ready;

  // Out-of-range widths are clamped so the shift register always aligns sanely.
  assign nb_clamped = (cfg_data_bits < NB_MIN) ? NB_MIN :
                      (cfg_data_bits > NB_MAX) ? NB_MAX : cfg_data_bits;

  // Bits enter at the MSB, so a short frame sits in the top bits until aligned.
  assign aligned = data_sh >> (NB_MAX - nb_q);

  always_ff @(posedge bclk) begin
    if (reset) begin
      sync     <= '1;
      state    <= ST_IDLE;
      cnt      <= '0;
      v_a      <= 1'b0;
      v_b      <= 1'b0;
      data_sh  <= '0;
      bit_idx  <= '0;
      nb_q     <= '0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      stop2_q  <= 1'b0;
      stop_idx <= 1'b0;
      perr_q   <= 1'b0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      perr_o   <= 1'b0;
      ferr_o   <= 1'b0;
      brk_o    <= 1'b0;
      ovr_o    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};

      if (counting) begin
        cnt <= (cnt == C_LAST) ? '0 : cnt + CW'(1);
        if (cnt == C_S0) v_a <= rx_s;
        if (cnt == C_S1) v_b <= rx_s;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            cnt      <= '0;
            nb_q     <= nb_clamped;
            par_en_q <= cfg_parity_en;
            odd_q    <= cfg_parity_odd;
            stop2_q  <= cfg_stop2;
            data_sh  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt == C_DEC && maj)
            state <= ST_IDLE;
          else if (cnt == C_LAST)
            state <= ST_DATA;
        end
        ST_DATA: begin
          if (cnt == C_DEC)
            data_sh <= {maj, data_sh[DATA_WIDTH-1:1]};
          if (cnt == C_LAST) begin
            if (bit_idx == nb_q - NBW'(1))
              state <= par_en_q ? ST_PARITY : ST_STOP;
            else
              bit_idx <= bit_idx + NBW'(1);
          end
        end
        ST_PARITY: begin
          if (cnt == C_DEC)
            perr_q <= (maj != ((^data_sh) ^ odd_q));
          if (cnt == C_LAST)
            state <= ST_STOP;
        end
        ST_STOP: begin
          if (cnt == C_DEC) begin
            if (done)
              state <= maj ? ST_IDLE : ST_WAIT_IDLE;
            else
              stop_idx <= 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Holding register: a completion coinciding with an accept replaces the entry.
      if (done) begin
        if (hold_free) begin
          data_o  <= aligned;
          valid_o <= 1'b1;
          perr_o  <= perr_q;
          ferr_o  <= !maj;
          brk_o   <= !maj && (data_sh == '0);
          if (valid_o) ovr_o <= 1'b0;
        end else begin
          ovr_o <= 1'b1;
        end
      end else if (valid_o && rx_if.rx_ready) begin
        valid_o <= 1'b0;
        ovr_o   <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data     = data_o;
  assign rx_if.rx_valid    = valid_o;
  assign rx_if.err_parity  = perr_o;
  assign rx_if.err_frame   = ferr_o;
  assign rx_if.err_overrun = ovr_o;
  assign rx_if.break_det   = brk_o;
  assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_edabk_uart_rx_engine.sv
// Bench for the UART receive engine: directed frames plus randomized frame formats,
// checked against a frame-level expectation queue.
module tb_edabk_uart_rx_engine;
  localparam int CLK_DIV = 16;
  localparam int DW      = 8;
  localparam int SYNC    = 2;
  localparam int H       = CLK_DIV / 2;

  logic       bclk = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic       busy;

  edabk_uart_rx_engine_if #(.DATA_WIDTH(DW)) rif ();

  edabk_uart_rx_engine #(
    .CLK_DIV(CLK_DIV), .DATA_WIDTH(DW), .SYNC_STAGES(SYNC)
  ) dut (
    .bclk(bclk), .reset(reset), .rx(rx),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
    .rx_if(rif), .busy(busy)
  );

  always #5 bclk = ~bclk;

  int cyc = 0;
  always @(posedge bclk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    logic       ovr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   last_hs_cyc = -1;
  int   k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge bclk);
      #1;
    end
  endtask

  function automatic logic [7:0] mask(input logic [7:0] d, input int nb);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < nb; i++) m[i] = d[i];
    return m;
  endfunction

  // Frame-level outcome derived only from what was put on the wire.
  function automatic exp_t model(input logic [7:0] dm, input logic pe, input logic s2,
                                 input logic pflip, input int stop_bad, input logic ovr);
    exp_t r;
    r.data = dm;
    r.perr = pe && pflip;
    r.ferr = (stop_bad == 1) || (stop_bad == 2 && s2);
    r.brk  = r.ferr && (dm == 8'h00);
    r.ovr  = ovr;
    return r;
  endfunction

  // Leaves rx at the level of the last stop bit; caller returns the line to idle.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pe, input logic po,
                            input logic s2, input logic pflip, input int stop_bad,
                            input logic scramble);
    logic [7:0] dm;
    logic       pbit;
    dm             = mask(d, nb);
    pbit           = (^dm) ^ po ^ pflip;
    cfg_data_bits  = 4'(nb);
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_stop2      = s2;
    rx = 1'b0;
    tick(CLK_DIV);
    if (scramble) begin
      cfg_data_bits  = 4'($urandom_range(5, 8));
      cfg_parity_en  = 1'($urandom_range(0, 1));
      cfg_parity_odd = 1'($urandom_range(0, 1));
      cfg_stop2      = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nb; i++) begin
      rx = dm[i];
      tick(CLK_DIV);
    end
    if (pe) begin
      rx = pbit;
      tick(CLK_DIV);
    end
    rx = (stop_bad != 1);
    tick(CLK_DIV);
    if (s2) begin
      rx = (stop_bad != 2);
      tick(CLK_DIV);
    end
  endtask

  always @(negedge bclk) begin
    if (reset === 1'b0 && rif.rx_valid === 1'b1 && rif.rx_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_frame", 32'(rif.rx_data), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("rx_data",     32'(rif.rx_data),     32'(e.data));
        chk("err_parity",  32'(rif.err_parity),  32'(e.perr));
        chk("err_frame",   32'(rif.err_frame),   32'(e.ferr));
        chk("break_det",   32'(rif.break_det),   32'(e.brk));
        chk("err_overrun", 32'(rif.err_overrun), 32'(e.ovr));
        last_hs_cyc = cyc;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         nb;
    logic       pe, po, s2, pflip;
    int         sb;

    reset = 1'b1;
    rx = 1'b1;
    rif.rx_ready = 1'b1;
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_stop2 = 1'b0;
    tick(3);
    chk("reset_valid",   32'(rif.rx_valid),    32'd0);
    chk("reset_data",    32'(rif.rx_data),     32'd0);
    chk("reset_perr",    32'(rif.err_parity),  32'd0);
    chk("reset_ferr",    32'(rif.err_frame),   32'd0);
    chk("reset_ovr",     32'(rif.err_overrun), 32'd0);
    chk("reset_brk",     32'(rif.break_det),   32'd0);
    chk("reset_busy",    32'(busy),            32'd0);
    reset = 1'b0;
    tick(5);

    // 8N1 0xA5 with start-edge to rx_valid latency
    q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0, brk: 1'b0, ovr: 1'b0});
    k = cyc;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rx = 1'b1;
    tick(20);
    chk("a5_latency", 32'(last_hs_cyc), 32'(k + 1 + SYNC + 9*CLK_DIV + H + 2));

    // 8E1 0x3C: wrong parity bit (1), then correct (0)
    q.push_back('{data: 8'h3C, perr: 1'b1, ferr: 1'b0, brk: 1'b0, ovr: 1'b0});
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    rx = 1'b1;
    tick(10);
    q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0, brk: 1'b0, ovr: 1'b0});
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rx = 1'b1;
    tick(10);

    // 7O2 0x55 with bad second stop; line held low afterwards
    q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1, brk: 1'b0, ovr: 1'b0});
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    tick(40);
    chk("wait_idle_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    tick(SYNC + 2);
    chk("wait_idle_exit", 32'(busy), 32'd0);
    tick(10);

    // 3-cycle glitch: false start
    k = cyc;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2);
    chk("glitch_busy_on", 32'(busy), 32'd1);
    tick(9);
    chk("glitch_busy_off", 32'(busy), 32'd0);
    tick(30);

    // Break: line low for two frame times
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_stop2 = 1'b0;
    q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1, ovr: 1'b0});
    rx = 1'b0;
    tick(20 * CLK_DIV);
    rx = 1'b1;
    tick(20);
    chk("break_busy_off", 32'(busy), 32'd0);

    // Overrun: consumer stalled across two frames
    rif.rx_ready = 1'b0;
    q.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0, brk: 1'b0, ovr: 1'b1});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rx = 1'b1;
    tick(5);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rx = 1'b1;
    tick(5);
    chk("ovr_valid_held", 32'(rif.rx_valid),    32'd1);
    chk("ovr_data_held",  32'(rif.rx_data),     32'h11);
    chk("ovr_flag_set",   32'(rif.err_overrun), 32'd1);
    rif.rx_ready = 1'b1;
    tick(1);
    chk("ovr_valid_clr",  32'(rif.rx_valid),    32'd0);
    chk("ovr_flag_clr",   32'(rif.err_overrun), 32'd0);
    tick(5);

    // Reset in the middle of a frame
    rx = 1'b0;
    tick(3 * CLK_DIV);
    reset = 1'b1;
    rx = 1'b1;
    tick(1);
    chk("midreset_busy",  32'(busy),          32'd0);
    chk("midreset_valid", 32'(rif.rx_valid),  32'd0);
    reset = 1'b0;
    tick(30);
    chk("midreset_idle",  32'(busy),          32'd0);

    // Randomized formats, data, parity and stop corruption; cfg scrambled mid-frame
    for (int n = 0; n < 40; n++) begin
      nb    = $urandom_range(5, 8);
      pe    = 1'($urandom_range(0, 1));
      po    = 1'($urandom_range(0, 1));
      s2    = 1'($urandom_range(0, 1));
      d     = 8'($urandom);
      if ($urandom_range(0, 9) == 0) d = 8'h00;
      pflip = ($urandom_range(0, 5) == 0);
      sb    = 0;
      if ($urandom_range(0, 5) == 0) sb = s2 ? int'($urandom_range(1, 2)) : 1;
      q.push_back(model(mask(d, nb), pe, s2, pflip, sb, 1'b0));
      send_frame(d, nb, pe, po, s2, pflip, sb, 1'b1);
      rx = 1'b1;
      tick((sb != 0) ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 20)));
    end

    for (int w = 0; w < 400 && q.size() != 0; w++) tick(1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
